// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the MEM-stage FSM encoding.
package cpu_pkg;
    localparam int DW_DEF = 16;
    localparam int RW_DEF = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;
endpackage

// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register: captures the EX outputs when enabled, turning invalid slots into bubbles.
module exmem_pipe_reg
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_alu_out,
    input  logic [DW-1:0] ex_store_data,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic          ex_reg_write,
    input  logic [RW-1:0] ex_rd,
    output logic          q_valid,
    output logic [DW-1:0] q_alu,
    output logic [DW-1:0] q_sdata,
    output logic          q_mem_read,
    output logic          q_mem_write,
    output logic          q_reg_write,
    output logic [RW-1:0] q_rd
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid     <= 1'b0;
            q_alu       <= '0;
            q_sdata     <= '0;
            q_mem_read  <= 1'b0;
            q_mem_write <= 1'b0;
            q_reg_write <= 1'b0;
            q_rd        <= '0;
        end else if (en) begin
            q_valid     <= ex_valid;
            q_alu       <= ex_alu_out;
            q_sdata     <= ex_store_data;
            q_mem_read  <= ex_valid & ex_mem_read;
            q_mem_write <= ex_valid & ex_mem_write;
            // R0 is hardwired, so a write to it is dropped here once for all consumers
            q_reg_write <= ex_valid & ex_reg_write & (ex_rd != '0);
            q_rd        <= ex_rd;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM register, blocking data-memory handshake FSM and MEM/WB register.
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_alu_out,
    input  logic [DW-1:0] ex_store_data,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic          ex_reg_write,
    input  logic [RW-1:0] ex_rd,
    output logic          stall_out,
    output logic [DW-1:0] mem_faddress,
    output logic [RW-1:0] mem_rd,
    output logic          mem_reg_write,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          wb_valid,
    output logic          wb_reg_write,
    output logic [DW-1:0] wb_data,
    output logic [RW-1:0] wb_rd
);
    mem_state_e    state, state_nxt;
    logic          m_valid, m_mem_read, m_mem_write;
    logic [DW-1:0] m_alu, m_sdata;
    logic          m_is_load, m_is_mem;
    logic          wb_valid_nxt, wb_rw_nxt;
    logic [DW-1:0] wb_data_nxt;

    exmem_pipe_reg #(.DW(DW), .RW(RW)) u_exmem (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (~stall_out),
        .ex_valid     (ex_valid),
        .ex_alu_out   (ex_alu_out),
        .ex_store_data(ex_store_data),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
        .q_valid      (m_valid),
        .q_alu        (m_alu),
        .q_sdata      (m_sdata),
        .q_mem_read   (m_mem_read),
        .q_mem_write  (m_mem_write),
        .q_reg_write  (mem_reg_write),
        .q_rd         (mem_rd)
    );

    // Store wins when both read and write are flagged
    assign m_is_load = m_mem_read & ~m_mem_write;
    assign m_is_mem  = m_mem_read | m_mem_write;

    assign stall_out    = (state == ACCESS);
    assign mem_faddress = m_alu;
    assign dmem_req     = (state == ACCESS);
    assign dmem_we      = m_mem_write;
    assign dmem_addr    = m_alu;
    assign dmem_wdata   = m_sdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        wb_valid_nxt = 1'b0;
        wb_rw_nxt    = 1'b0;
        wb_data_nxt  = m_alu;
        case (state)
            IDLE: begin
                // Decide on the entry being captured this edge, not the one already held
                if (ex_valid && (ex_mem_read || ex_mem_write)) state_nxt = ACCESS;
                // A completed memory op lingers one IDLE cycle in EX/MEM; keep it out of WB
                wb_valid_nxt = m_valid & ~m_is_mem;
                wb_rw_nxt    = mem_reg_write & ~m_is_mem;
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_nxt    = IDLE;
                    wb_valid_nxt = 1'b1;
                    wb_rw_nxt    = m_is_load & mem_reg_write;
                    if (m_is_load) wb_data_nxt = dmem_rdata;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
        end else begin
            wb_valid     <= wb_valid_nxt;
            wb_reg_write <= wb_rw_nxt;
            wb_data      <= wb_data_nxt;
            wb_rd        <= mem_rd;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: ALU vector table, memory-op sequences and a WB scoreboard.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [15:0] ex_alu_out, ex_store_data;
    logic [3:0]  ex_rd;
    logic        stall_out, mem_reg_write, dmem_req, dmem_we, dmem_ack;
    logic [15:0] mem_faddress, dmem_addr, dmem_wdata, dmem_rdata, wb_data;
    logic [3:0]  mem_rd, wb_rd;
    logic        wb_valid, wb_reg_write;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  rd;
        logic        rw;
    } wb_exp_t;
    wb_exp_t sb[$];

    typedef struct {
        logic [15:0] alu;
        logic [3:0]  rd;
        logic        rw;
        logic        valid;
        logic        exp_mrw;
    } vec_t;
    vec_t tbl[6];

    mem_access_stage #(.DW(16), .RW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .stall_out(stall_out), .mem_faddress(mem_faddress), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_data(wb_data), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // WB scoreboard: every valid WB output must match the oldest expected retirement
    always @(negedge clk) begin : wb_mon
        wb_exp_t e;
        if (rst_n && wb_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected actual data=%0h required=none t=%0t", wb_data, $time);
            end else begin
                e = sb.pop_front();
                chk("wb_data", 32'(wb_data), 32'(e.data));
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
            end
        end
    end

    // Called at a negedge; returns at the negedge after capture with ex_valid dropped
    task automatic alu_op(input logic v, input logic [15:0] alu, input logic [3:0] rd,
                          input logic rw, input logic exp_mrw);
        ex_valid = v; ex_alu_out = alu; ex_store_data = 16'($urandom);
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = rw; ex_rd = rd;
        if (v) sb.push_back('{alu, rd, exp_mrw});
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0;
        chk("alu_faddress", 32'(mem_faddress), 32'(alu));
        if (v) chk("alu_mem_rd", 32'(mem_rd), 32'(rd));
        chk("alu_mem_reg_write", 32'(mem_reg_write), 32'(exp_mrw));
        chk("alu_stall", 32'(stall_out), 32'd0);
    endtask

    task automatic mem_op(input logic [15:0] addr, input logic [15:0] sdata, input logic mr,
                          input logic mw, input logic rw, input logic [3:0] rd,
                          input int lat, input logic [15:0] rdata);
        logic is_load;
        is_load = mr & ~mw;
        ex_valid = 1'b1; ex_alu_out = addr; ex_store_data = sdata;
        ex_mem_read = mr; ex_mem_write = mw; ex_reg_write = rw; ex_rd = rd;
        sb.push_back('{is_load ? rdata : addr, rd, is_load ? (rw && rd != 4'd0) : 1'b0});
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0;
        chk("mem_faddress", 32'(mem_faddress), 32'(addr));
        for (int i = 1; i <= lat; i++) begin
            chk("acc_stall", 32'(stall_out), 32'd1);
            chk("acc_req", 32'(dmem_req), 32'd1);
            chk("acc_addr", 32'(dmem_addr), 32'(addr));
            chk("acc_we", 32'(dmem_we), 32'(mw));
            if (mw) chk("acc_wdata", 32'(dmem_wdata), 32'(sdata));
            if (i == lat) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdata;
            end
            @(posedge clk); @(negedge clk);
        end
        dmem_ack = 1'b0;
        dmem_rdata = 16'h0;
        chk("post_ack_stall", 32'(stall_out), 32'd0);
        chk("post_ack_req", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        tbl[0] = '{16'h1234, 4'd3,  1'b1, 1'b1, 1'b1};
        tbl[1] = '{16'h0001, 4'd0,  1'b1, 1'b1, 1'b0};
        tbl[2] = '{16'hFFFF, 4'd15, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{16'h5555, 4'd7,  1'b0, 1'b1, 1'b0};
        tbl[4] = '{16'hAAAA, 4'd5,  1'b1, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 4'd9,  1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        ex_valid = 1'b0; ex_alu_out = '0; ex_store_data = '0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0; ex_rd = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_mem_reg_write", 32'(mem_reg_write), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_faddress", 32'(mem_faddress), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) alu_op(tbl[i].valid, tbl[i].alu, tbl[i].rd, tbl[i].rw, tbl[i].exp_mrw);
        repeat (2) @(negedge clk);

        mem_op(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd5, 3, 16'hBEEF);
        mem_op(16'h0010, 16'h00AA, 1'b0, 1'b1, 1'b1, 4'd6, 1, 16'h1111);
        mem_op(16'h0020, 16'h1357, 1'b1, 1'b1, 1'b1, 4'd2, 2, 16'h2222);
        alu_op(1'b1, 16'h4321, 4'd4, 1'b1, 1'b1);
        mem_op(16'h0080, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd0, 1, 16'h7777);
        alu_op(1'b1, 16'h0BAD, 4'd1, 1'b1, 1'b1);

        // Stray ack while idle must be ignored
        dmem_ack = 1'b1; dmem_rdata = 16'hCAFE;
        @(posedge clk); @(negedge clk);
        chk("stray_ack_stall", 32'(stall_out), 32'd0);
        chk("stray_ack_req", 32'(dmem_req), 32'd0);
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of an access abandons it
        ex_valid = 1'b1; ex_alu_out = 16'h0090; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_reg_write = 1'b1; ex_rd = 4'd8;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0;
        chk("mid_acc_stall", 32'(stall_out), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_acc_req", 32'(dmem_req), 32'd0);
        chk("rst_acc_stall", 32'(stall_out), 32'd0);
        chk("rst_acc_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_acc_mem_reg_write", 32'(mem_reg_write), 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            chk("post_rst_stall", 32'(stall_out), 32'd0);
            chk("post_rst_req", 32'(dmem_req), 32'd0);
            chk("post_rst_wb_valid", 32'(wb_valid), 32'd0);
        end
        dmem_ack = 1'b0;

        alu_op(1'b1, 16'h7E57, 4'd12, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
